// File: rtl/sa_result_collector.sv
// sa_result_collector
// Bottom-edge result collector for the systolic array. Column results arrive
// staggered by one cycle per column; each column is delayed so that a whole
// row lines up in one cycle. Aligned rows are stored in a circular buffer and
// presented downstream over a valid/ready handshake with zero read latency.
// Status flags (F/AF/E/AE) are decoded from the registered row count only.

module sa_result_collector #(
   parameter int N_COLS = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [N_COLS*DATA_W-1:0]     col_data_i,
   input  logic [N_COLS-1:0]            col_valid_i,
   input  logic                         clear_i,
   output logic [N_COLS*DATA_W-1:0]     row_data_o,
   output logic                         row_valid_o,
   input  logic                         row_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         F,
   output logic                         AF,
   output logic                         E,
   output logic                         AE,
   output logic                         overflow_o,
   output logic                         skew_err_o
);

   localparam int ROW_W = N_COLS * DATA_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Aligned (de-skewed) row as seen at the buffer input.
   logic [ROW_W-1:0]  al_data_s;
   logic [N_COLS-1:0] al_valid_s;

   // ------------------------------------------------------------------
   // De-skew: column c is delayed by (N_COLS-1-c) stages so that all
   // columns of one row meet in the cycle the last column arrives.
   // ------------------------------------------------------------------
   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      localparam int D = N_COLS - 1 - c;

      if (D == 0) begin : g_pass
         assign al_data_s[c*DATA_W +: DATA_W] = col_data_i[c*DATA_W +: DATA_W];
         assign al_valid_s[c]                 = col_valid_i[c];
      end else begin : g_dly
         logic [DATA_W-1:0] dat_q [D];
         logic [DATA_W-1:0] dat_d [D];
         logic [D-1:0]      vld_q;
         logic [D-1:0]      vld_d;

         // Shift the column through its delay line; clear flushes it.
         always_comb begin
            for (int s = 0; s < D; s++) begin
               dat_d[s] = {DATA_W{1'b0}};
            end
            vld_d = {D{1'b0}};
            if (clear_i) begin
               vld_d = {D{1'b0}};
            end else begin
               dat_d[0] = col_data_i[c*DATA_W +: DATA_W];
               vld_d[0] = col_valid_i[c];
               for (int s = 1; s < D; s++) begin
                  dat_d[s] = dat_q[s-1];
                  vld_d[s] = vld_q[s-1];
               end
            end
         end

         // Delay-line registers.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               for (int s = 0; s < D; s++) begin
                  dat_q[s] <= {DATA_W{1'b0}};
               end
               vld_q <= {D{1'b0}};
            end else begin
               for (int s = 0; s < D; s++) begin
                  dat_q[s] <= dat_d[s];
               end
               vld_q <= vld_d;
            end
         end

         assign al_data_s[c*DATA_W +: DATA_W] = dat_q[D-1];
         assign al_valid_s[c]                 = vld_q[D-1];
      end
   end

   // ------------------------------------------------------------------
   // Row buffer
   // ------------------------------------------------------------------
   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             skew_q, skew_d;

   logic push_req_s;
   logic skew_hit_s;
   logic pop_s;
   logic full_s;
   logic empty_s;
   logic wr_en_s;

   assign push_req_s = &al_valid_s;
   assign skew_hit_s = (|al_valid_s) && !(&al_valid_s);
   assign empty_s    = (count_q == CNT_ZERO);
   assign full_s     = (count_q == CNT_FULL);
   assign pop_s      = !empty_s && row_ready_i;

   // Pointer, count and sticky-flag next state; clear beats push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      skew_d   = skew_q;
      wr_en_s  = 1'b0;
      if (clear_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = CNT_ZERO;
         ovf_d    = 1'b0;
         skew_d   = 1'b0;
      end else begin
         // A push into a full buffer only fits when the head leaves this cycle.
         if (push_req_s && (!full_s || pop_s)) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else if (push_req_s) begin
            ovf_d = 1'b1;
         end else begin
            wr_en_s = 1'b0;
         end

         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase

         if (skew_hit_s) begin
            skew_d = 1'b1;
         end else begin
            skew_d = skew_q;
         end
      end
   end

   // Control registers: pointers, count, sticky flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= CNT_ZERO;
         ovf_q    <= 1'b0;
         skew_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         skew_q   <= skew_d;
      end
   end

   // Row storage; zeroed on reset so the head never shows X while empty.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ROW_W{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_q[wr_ptr_q] <= al_data_s;
      end
   end

   // Head entry is read straight from storage: no output register.
   assign row_data_o  = mem_q[rd_ptr_q];
   assign row_valid_o = !empty_s;
   assign count_o     = count_q;
   assign E           = empty_s;
   assign F           = full_s;
   assign AE          = (count_q <= CNT_ONE);
   assign AF          = (count_q >= CNT_AF);
   assign overflow_o  = ovf_q;
   assign skew_err_o  = skew_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Testbench for sa_result_collector: directed skewed-row stimulus, a
// queue-based reference model checked every cycle, plus literal spot checks.

module tb_sa_result_collector;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int RW    = N * W;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          CLK = 1'b0;
   logic          RST;
   logic [RW-1:0] col_data_i;
   logic [N-1:0]  col_valid_i;
   logic          clear_i;
   logic [RW-1:0] row_data_o;
   logic          row_valid_o;
   logic          row_ready_i;
   logic [CW-1:0] count_o;
   logic          F, AF, E, AE;
   logic          overflow_o;
   logic          skew_err_o;

   always #5 CLK = ~CLK;

   sa_result_collector #(.N_COLS(N), .DATA_W(W), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .col_data_i (col_data_i),
      .col_valid_i(col_valid_i),
      .clear_i    (clear_i),
      .row_data_o (row_data_o),
      .row_valid_o(row_valid_o),
      .row_ready_i(row_ready_i),
      .count_o    (count_o),
      .F          (F),
      .AF         (AF),
      .E          (E),
      .AE         (AE),
      .overflow_o (overflow_o),
      .skew_err_o (skew_err_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Row "v": column c carries v*16 + c + 1.
   function automatic logic [RW-1:0] rowword(input int v);
      logic [RW-1:0] w;
      w = '0;
      for (int c = 0; c < N; c++) w[c*W +: W] = W'(v * 16 + c + 1);
      return w;
   endfunction

   // ---------------- reference model ----------------
   // The buffer is a queue of row words; the alignment is expressed as
   // "column c sees the input it received N-1-c cycles ago".
   logic [RW-1:0] mq[$];
   logic          m_ovf  = 1'b0;
   logic          m_skew = 1'b0;
   logic [N-1:0]  hv [1:N-1];
   logic [RW-1:0] hd [1:N-1];

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_skew = 1'b0;
      for (int d = 1; d < N; d++) begin
         hv[d] = '0;
         hd[d] = '0;
      end
   endtask

   task automatic model_step();
      logic [N-1:0]  av;
      logic [RW-1:0] ad;
      bit            full, pop;
      av = '0;
      ad = '0;
      for (int c = 0; c < N; c++) begin
         if (N - 1 - c == 0) begin
            av[c]        = col_valid_i[c];
            ad[c*W +: W] = col_data_i[c*W +: W];
         end else begin
            av[c]        = hv[N-1-c][c];
            ad[c*W +: W] = hd[N-1-c][c*W +: W];
         end
      end
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && row_ready_i;
      if (clear_i) begin
         model_reset();
      end else begin
         if (pop) void'(mq.pop_front());
         if (&av) begin
            if (!full || pop) mq.push_back(ad);
            else m_ovf = 1'b1;
         end
         if ((|av) && !(&av)) m_skew = 1'b1;
         for (int d = N - 1; d >= 2; d--) begin
            hv[d] = hv[d-1];
            hd[d] = hd[d-1];
         end
         hv[1] = col_valid_i;
         hd[1] = col_data_i;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or posedge RST);
         if (RST) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   bit            cap_en  = 1'b0;
   logic [RW-1:0] popped[$];
   int            max_cnt = 0;

   task automatic compare();
      int sz;
      sz = mq.size();
      check("row_valid", row_valid_o, 64'(sz > 0));
      if (sz > 0) check("row_data", row_data_o, mq[0]);
      check("count", count_o, 64'(sz));
      check("E",  E,  64'(sz == 0));
      check("F",  F,  64'(sz == DEPTH));
      check("AE", AE, 64'(sz <= 1));
      check("AF", AF, 64'(sz >= DEPTH - 1));
      check("overflow", overflow_o, m_ovf);
      check("skew_err", skew_err_o, m_skew);
      if (cap_en && row_valid_o && row_ready_i) popped.push_back(row_data_o);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         compare();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [N-1:0] v, input logic [RW-1:0] d,
                        input logic rdy, input logic clr);
      col_valid_i = v;
      col_data_i  = d;
      row_ready_i = rdy;
      clear_i     = clr;
      @(posedge CLK);
      #1;
   endtask

   // n rows starting at id "first", one row every "stride" cycles, columns
   // skewed by one cycle. rmode: 0 ready low, 1 ready high, 2 toggling,
   // 3 ready high only in the last cycle.
   task automatic send_rows(input int first, input int n, input int stride, input int rmode);
      int            tot;
      logic [N-1:0]  v;
      logic [RW-1:0] d;
      logic [RW-1:0] rw;
      logic          rdy;
      tot = (n - 1) * stride + N;
      for (int t = 0; t < tot; t++) begin
         v = '0;
         d = '0;
         for (int c = 0; c < N; c++) begin
            if ((t - c) >= 0 && ((t - c) % stride) == 0 && ((t - c) / stride) < n) begin
               rw           = rowword(first + (t - c) / stride);
               v[c]         = 1'b1;
               d[c*W +: W]  = rw[c*W +: W];
            end
         end
         case (rmode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = logic'(t % 2);
            default: rdy = (t == tot - 1);
         endcase
         drive(v, d, rdy, 1'b0);
      end
      col_valid_i = '0;
      col_data_i  = '0;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive('0, '0, rdy, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0]  v;
      logic [RW-1:0] d;

      RST = 1'b1;
      col_valid_i = '0;
      col_data_i  = '0;
      clear_i     = 1'b0;
      row_ready_i = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_count", count_o, 64'd0);
      check("rst_E", E, 64'd1);
      check("rst_AE", AE, 64'd1);
      check("rst_F", F, 64'd0);
      check("rst_AF", AF, 64'd0);
      check("rst_row_valid", row_valid_o, 64'd0);
      check("rst_row_data", row_data_o, 64'd0);
      RST = 1'b0;

      // Latency: valid only in cycle 4 with ready held high.
      for (int t = 0; t < 8; t++) begin
         v = '0;
         d = '0;
         if (t < N) begin
            v[t]        = 1'b1;
            d[t*W +: W] = W'(t + 1);
         end
         col_valid_i = v;
         col_data_i  = d;
         row_ready_i = 1'b1;
         clear_i     = 1'b0;
         #3;
         check("lat_valid", row_valid_o, 64'(t == 4));
         if (t == 4) check("lat_data", row_data_o, 64'h0004_0003_0002_0001);
         @(posedge CLK);
         #1;
      end

      // Fill and overflow.
      send_rows(1, 7, 1, 0);
      check("fill7_count", count_o, 64'd7);
      check("fill7_AF", AF, 64'd1);
      check("fill7_F", F, 64'd0);
      send_rows(8, 2, 1, 0);
      check("fill9_count", count_o, 64'd8);
      check("fill9_F", F, 64'd1);
      check("fill9_overflow", overflow_o, 64'd1);
      check("fill_head", row_data_o, rowword(1));
      idle(8, 1'b1);
      check("drain_E", E, 64'd1);

      // Full with simultaneous push and pop.
      drive('0, '0, 1'b0, 1'b1);
      check("clr_overflow", overflow_o, 64'd0);
      send_rows(1, 8, 1, 0);
      check("full_F", F, 64'd1);
      send_rows(9, 1, 1, 3);
      check("pp_count", count_o, 64'd8);
      check("pp_overflow", overflow_o, 64'd0);
      check("pp_head", row_data_o, rowword(2));
      idle(9, 1'b1);
      check("pp_drain_E", E, 64'd1);

      // Skew error: column 2 one cycle late.
      send_rows(40, 2, 1, 0);
      d = rowword(30);
      drive(4'b0001, d, 1'b0, 1'b0);
      drive(4'b0010, d, 1'b0, 1'b0);
      drive(4'b0000, d, 1'b0, 1'b0);
      drive(4'b1100, d, 1'b0, 1'b0);
      idle(3, 1'b0);
      check("skew_count", count_o, 64'd2);
      check("skew_flag", skew_err_o, 64'd1);
      drive('0, '0, 1'b0, 1'b1);
      check("skew_clr_flag", skew_err_o, 64'd0);
      check("skew_clr_E", E, 64'd1);

      // Reset mid-burst with three rows stored.
      send_rows(50, 3, 1, 0);
      check("pre_rst_count", count_o, 64'd3);
      d = rowword(60);
      drive(4'b0001, d, 1'b0, 1'b0);
      col_valid_i = 4'b0010;
      #2;
      RST = 1'b1;
      #1;
      check("mrst_count", count_o, 64'd0);
      check("mrst_E", E, 64'd1);
      check("mrst_AE", AE, 64'd1);
      check("mrst_row_valid", row_valid_o, 64'd0);
      check("mrst_row_data", row_data_o, 64'd0);
      check("mrst_overflow", overflow_o, 64'd0);
      check("mrst_skew", skew_err_o, 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      drive(4'b0100, d, 1'b0, 1'b0);
      drive(4'b1000, d, 1'b0, 1'b0);
      send_rows(70, 1, 1, 0);
      check("post_rst_count", count_o, 64'd1);
      check("post_rst_head", row_data_o, rowword(70));
      drive('0, '0, 1'b0, 1'b1);

      // Wrap-around: 20 rows, ready toggling every cycle.
      popped.delete();
      max_cnt = 0;
      cap_en  = 1'b1;
      send_rows(1, 20, 2, 2);
      idle(12, 1'b1);
      cap_en = 1'b0;
      check("wrap_pops", 64'(popped.size()), 64'd20);
      for (int i = 0; i < popped.size(); i++) check("wrap_order", popped[i], rowword(i + 1));
      check("wrap_max_le8", 64'(max_cnt <= DEPTH), 64'd1);
      check("wrap_overflow", overflow_o, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_result_collector.md
Name: sa_result_collector

Overview:
- Output-side counterpart to the horizontal input FIFOs that feed skewed operands into the systolic array.
- Captures the staggered column results from the array's bottom edge and de-skews them into aligned row words.
- Buffers those rows in a circular FIFO and hands them downstream over a valid/ready handshake.
- Exposes the same F/AF/E/AE status flag set as the input FIFOs.

Parameters:
- N_COLS, 4, number of array columns (>=2).
- DATA_W, 16, bits per column result.
- DEPTH, 8, row-buffer entries (power of two, >=4).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- col_data_i  input  N_COLS*DATA_W  column results; column c occupies bits [c*DATA_W +: DATA_W].
- col_valid_i  input  N_COLS  per-column result strobe.
- clear_i  input  1  synchronous flush of the buffer and the de-skew pipeline.
- row_data_o  output  N_COLS*DATA_W  head-of-buffer row word, same column packing as col_data_i.
- row_valid_o  output  1  head entry present.
- row_ready_i  input  1  downstream accepts the head entry.
- count_o  output  $clog2(DEPTH+1)  stored row count.
- F, AF, E, AE  output  1 each  full, almost-full, empty, almost-empty.
- overflow_o  output  1  sticky: a row was dropped.
- skew_err_o  output  1  sticky: aligned valids disagreed.

Behaviour:
- Reset (RST high, async): pointers, count, de-skew registers, overflow_o and skew_err_o all cleared.
  - Outputs under reset: row_valid_o=0, row_data_o=0, count_o=0, E=1, AE=1, F=0, AF=0.
- Input timing: for one result row, column c asserts col_valid_i[c] exactly c cycles after column 0.
- De-skew: column c data and valid pass through (N_COLS-1-c) registered stages; column N_COLS-1 is unregistered.
- Aligned row: all delayed valids high in the same cycle -> push the concatenated word at the next rising edge.
- Skew error: any delayed valid high but not all high -> no push; skew_err_o set (sticky until RST or clear_i).
- Latency: col_valid_i[0] in cycle k -> row_valid_o high in cycle k+N_COLS (cycle 4 for N_COLS=4). Back-to-back rows sustain 1 row/cycle.
- Buffer:
  - Circular; write and read pointers wrap modulo DEPTH.
  - row_data_o reads directly from the read pointer; no output register, zero read latency.
  - row_valid_o = !E.
  - Pop occurs on row_valid_o && row_ready_i.
- Flags:
  - E = (count==0); F = (count==DEPTH).
  - AE = (count<=1); AF = (count>=DEPTH-1).
  - All flags are derived from registered count, never combinationally from the inputs.
- Simultaneous events:
  - Push with F=1 and no pop: row dropped, count unchanged, overflow_o set (sticky).
  - Push and pop with F=1: both succeed, count stays DEPTH, no overflow.
  - Push with E=1: the pushed row is not visible until the next cycle; no bypass.
  - Push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Pop while E=1: ignored.
- clear_i: the next edge empties the buffer, zeroes the de-skew pipeline and clears both sticky flags.
  - Any push or pop in that same cycle is discarded.
  - clear_i takes priority over everything except RST.
- Reset mid-operation: partially de-skewed rows are lost; after RST deasserts, the first complete aligned row is accepted normally.
- Stored data is never modified after push; no X propagates on row_data_o while E=1 (holds the stale entry or reset zero).

Test Plan:
- Reset values: assert RST mid-burst with 3 rows stored -> immediately count_o=0, E=1, AE=1, row_valid_o=0, row_data_o=0, overflow_o=0, skew_err_o=0.
- Latency: one skewed row, columns 0..3 = 0x0001..0x0004 starting cycle 0, row_ready_i=1 -> row_valid_o=1 only in cycle 4, row_data_o=0x0004_0003_0002_0001.
- Fill and overflow: 9 consecutive skewed rows with values 1..9, row_ready_i=0 -> AF at count 7, F at count 8, row 9 dropped, overflow_o=1. Drain -> rows 1..8 in order, E=1 after 8 pops.
- Full push+pop: with F=1, push and pop in the same cycle -> count stays 8, overflow_o stays 0. Next pops return rows 2..9.
- Skew error: col_valid_i[2] asserted one cycle late for a row -> no push, count unchanged, skew_err_o=1. clear_i for one cycle -> skew_err_o=0, E=1.
- Wrap-around: 20 rows streamed with row_ready_i toggling every cycle -> output sequence 1..20 exact with no drops, pointers wrap at least twice, count_o never exceeds 8.
